// File: rtl/spi_master_ctrl.sv
// SPI master: serialises {op, payload} host commands as 10-bit MSB-first frames, collects 8-bit read-data replies.
// Latency: writes/rd-addr 1+10+IDLE_GAP cycles from handshake to ready; rd-data adds RD_WAIT+8, reply strobe at 1+10+RD_WAIT+8.
// Backpressure: cmd_ready is high only in IDLE, so the host holds cmd_valid until the frame in flight and its gap finish.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   cmd_valid/cmd_ready host command handshake; cmd_op (2b) and cmd_data (8b) are latched on it
//   rsp_valid/rsp_data  one-cycle reply strobe; rsp_data holds until the next reply
//   busy                high whenever the controller is not IDLE
//   ss_n, MOSI, MISO    frame select, serial out and serial in towards the SPI slave wrapper
module spi_master_ctrl #(
  parameter int RD_WAIT  = 2,  // cycles between last frame bit and first MISO sample, 0..15
  parameter int IDLE_GAP = 1   // cycles ss_n stays high after a frame, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_t;

  localparam logic [1:0] OP_RD_DATA = 2'b11;
  // Down-counters run N-1..0 so a state lasts exactly N cycles.
  localparam logic [3:0] RD_WAIT_M1 = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
  localparam logic [3:0] GAP_M1     = 4'(IDLE_GAP - 1);

  state_t     state_q, state_d;
  logic [9:0] frame_q, frame_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  // Only the seven most recent bits are kept; the eighth is taken straight from MISO on the final edge.
  logic [6:0] rx_q, rx_d;
  logic [7:0] rsp_data_d;
  logic       rsp_valid_d;
  logic       ss_n_d;
  logic       mosi_d;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data;
    rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ST_START;
          // Read-data carries no payload; send zeros regardless of cmd_data.
          frame_d = (cmd_op == OP_RD_DATA) ? {OP_RD_DATA, 8'h00} : {cmd_op, cmd_data};
        end
      end

      ST_START: begin
        state_d   = ST_SHIFT;
        bit_cnt_d = 4'd9;
      end

      ST_SHIFT: begin
        if (bit_cnt_q == 4'd0) begin
          // Bit counter is left at zero (saturated) until the next state reloads it.
          if (frame_q[9:8] == OP_RD_DATA) begin
            if (RD_WAIT == 0) begin
              state_d   = ST_RECV;
              bit_cnt_d = 4'd7;
            end else begin
              state_d    = ST_WAIT;
              wait_cnt_d = RD_WAIT_M1;
            end
          end else begin
            state_d    = ST_GAP;
            wait_cnt_d = GAP_M1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d   = ST_RECV;
          bit_cnt_d = 4'd7;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      ST_RECV: begin
        rx_d = {rx_q[5:0], MISO};
        if (bit_cnt_q == 4'd0) begin
          rsp_data_d  = {rx_q, MISO};
          rsp_valid_d = 1'b1;
          state_d     = ST_GAP;
          wait_cnt_d  = GAP_M1;
        end else begin
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end

      ST_GAP: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pins are registered from the next state so they line up with the state they belong to.
    ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    mosi_d = (state_d == ST_SHIFT) ? frame_d[bit_cnt_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      frame_q    <= 10'd0;
      bit_cnt_q  <= 4'd0;
      wait_cnt_q <= 4'd0;
      rx_q       <= 7'd0;
      rsp_data   <= 8'h00;
      rsp_valid  <= 1'b0;
      ss_n       <= 1'b1;
      MOSI       <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rx_q       <= rx_d;
      rsp_data   <= rsp_data_d;
      rsp_valid  <= rsp_valid_d;
      ss_n       <= ss_n_d;
      MOSI       <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: main instance (RD_WAIT=2, IDLE_GAP=1) against a behavioural
// SPI slave with a byte memory, plus a RD_WAIT=0 instance driven directly for the no-wait read path.
// Cycle k below counts clock periods after the handshake edge; k=0 is the START cycle.
module tb_spi_master_ctrl;
  localparam int RW  = 2;
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, rsp_valid, busy, ss_n, MOSI, MISO;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, rsp_data;

  logic       nw_cmd_valid, nw_cmd_ready, nw_rsp_valid, nw_busy, nw_ss_n, nw_mosi, nw_miso;
  logic [1:0] nw_cmd_op;
  logic [7:0] nw_cmd_data, nw_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_WAIT(RW), .IDLE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO)
  );

  spi_master_ctrl #(.RD_WAIT(0), .IDLE_GAP(1)) dut_nw (
    .clk(clk), .rst(rst), .cmd_valid(nw_cmd_valid), .cmd_ready(nw_cmd_ready), .cmd_op(nw_cmd_op),
    .cmd_data(nw_cmd_data), .rsp_valid(nw_rsp_valid), .rsp_data(nw_rsp_data), .busy(nw_busy),
    .ss_n(nw_ss_n), .MOSI(nw_mosi), .MISO(nw_miso)
  );

  // Behavioural slave: counts cycles with ss_n low, takes frame bits in cycles 1..10,
  // and replies to read-data MSB first in cycles 11+RW .. 18+RW.
  logic [7:0] sl_mem [0:255];
  logic [7:0] sl_waddr, sl_raddr, sl_reply, sl_fixed_val;
  logic [9:0] sl_sh;
  bit         sl_fixed = 1'b0;
  int         sl_idx = 0;
  logic [9:0] frames_q [$];

  always @(posedge clk) begin
    if (rst || ss_n) begin
      sl_idx = 0;
    end else begin
      if (sl_idx >= 1 && sl_idx <= 10) sl_sh = {sl_sh[8:0], MOSI};
      if (sl_idx == 10) begin
        frames_q.push_back(sl_sh);
        case (sl_sh[9:8])
          2'b00: sl_waddr = sl_sh[7:0];
          2'b01: sl_mem[sl_waddr] = sl_sh[7:0];
          2'b10: sl_raddr = sl_sh[7:0];
          default: sl_reply = sl_fixed ? sl_fixed_val : sl_mem[sl_raddr];
        endcase
      end
      sl_idx++;
    end
  end

  always @(negedge clk) begin
    if (!ss_n && sl_idx >= 11 + RW && sl_idx <= 18 + RW) MISO = sl_reply[7 - (sl_idx - 11 - RW)];
    else MISO = 1'b0;
  end

  // Per-cycle history of the main instance, filled by capture().
  logic       ss_h [0:63];
  logic       mosi_h [0:63];
  logic       rdy_h [0:63];
  logic       busy_h [0:63];
  logic       rv_h [0:63];
  logic [7:0] rd_h [0:63];

  task automatic capture(input int n, input bit drop);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0 && drop) cmd_valid = 1'b0;
      ss_h[k] = ss_n; mosi_h[k] = MOSI; rdy_h[k] = cmd_ready;
      busy_h[k] = busy; rv_h[k] = rsp_valid; rd_h[k] = rsp_data;
    end
  endtask

  // Presents a command and returns just after its handshake edge (ok=0 if never accepted).
  task automatic send(input logic [1:0] op, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
  endtask

  function automatic logic [9:0] shift_bits();
    logic [9:0] b;
    for (int k = 1; k <= 10; k++) b[10 - k] = mosi_h[k];
    return b;
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    nw_cmd_valid = 1'b0; nw_cmd_op = 2'b00; nw_cmd_data = 8'h00; nw_miso = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {ss_n, MOSI, rsp_valid, busy, rsp_data};
    n_checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_wr_addr();
    bit ok;
    int lows;
    send(2'b00, 8'h5A, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wr_addr_accept: got 0 expected 1"); end
    capture(16, 1'b1);
    n_checks++;
    if ({ss_h[0], mosi_h[0]} !== 2'b00) begin
      n_fail++; $display("FAIL wr_addr_start: got %b expected 00", {ss_h[0], mosi_h[0]});
    end
    n_checks++;
    if (shift_bits() !== 10'b0001011010) begin
      n_fail++; $display("FAIL wr_addr_bits: got %b expected 0001011010", shift_bits());
    end
    lows = 0;
    for (int k = 0; k < 16; k++) if (ss_h[k] === 1'b0) lows++;
    n_checks++;
    if (lows != 11 || ss_h[10] !== 1'b0 || ss_h[11] !== 1'b1) begin
      n_fail++; $display("FAIL wr_addr_ss_low: got %0d cycles expected 11", lows);
    end
    n_checks++;
    if ({rdy_h[10], rdy_h[11], rdy_h[12], busy_h[11], mosi_h[11]} !== 5'b00110) begin
      n_fail++; $display("FAIL wr_addr_ready: got %b expected 00110",
                         {rdy_h[10], rdy_h[11], rdy_h[12], busy_h[11], mosi_h[11]});
    end
  endtask

  task automatic test_wrapper_seq();
    bit ok, all_ok;
    int pulses;
    all_ok = 1'b1;
    sl_fixed = 1'b0;
    frames_q.delete();
    send(2'b00, 8'h10, ok); all_ok &= ok; capture(12, 1'b1);
    send(2'b01, 8'hA5, ok); all_ok &= ok; capture(12, 1'b1);
    send(2'b10, 8'h10, ok); all_ok &= ok; capture(12, 1'b1);
    send(2'b11, 8'h00, ok); all_ok &= ok; capture(24, 1'b1);
    n_checks++;
    if (!all_ok || frames_q.size() != 4) begin
      n_fail++; $display("FAIL seq_frames: got %0d frames expected 4", frames_q.size());
    end
    pulses = 0;
    for (int k = 0; k < 24; k++) if (rv_h[k] === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1 || rv_h[21] !== 1'b1) begin
      n_fail++; $display("FAIL seq_rsp_pulse: got %0d pulses expected 1 at cycle 21", pulses);
    end
    n_checks++;
    if (rd_h[21] !== 8'hA5) begin
      n_fail++; $display("FAIL seq_rsp_data: got %h expected a5", rd_h[21]);
    end
  endtask

  task automatic test_rd_data();
    bit ok;
    int pulses, lows, both;
    sl_fixed = 1'b1; sl_fixed_val = 8'hC3;
    send(2'b11, 8'hFF, ok);
    capture(26, 1'b1);
    sl_fixed = 1'b0;
    n_checks++;
    if (!ok || shift_bits() !== 10'b1100000000) begin
      n_fail++; $display("FAIL rd_bits: got %b expected 1100000000", shift_bits());
    end
    lows = 0; pulses = 0; both = 0;
    for (int k = 0; k < 26; k++) begin
      if (ss_h[k] === 1'b0) lows++;
      if (rv_h[k] === 1'b1) pulses++;
      if (rv_h[k] === 1'b1 && rdy_h[k] === 1'b1) both++;
    end
    n_checks++;
    if (lows != 11 + RW + 8) begin
      n_fail++; $display("FAIL rd_ss_low: got %0d cycles expected %0d", lows, 11 + RW + 8);
    end
    n_checks++;
    if (pulses != 1 || rv_h[19 + RW] !== 1'b1 || both != 0) begin
      n_fail++; $display("FAIL rd_pulse: got %0d pulses expected 1 at cycle %0d", pulses, 19 + RW);
    end
    n_checks++;
    if ({rd_h[18 + RW], rd_h[19 + RW], rd_h[25]} !== {8'hA5, 8'hC3, 8'hC3}) begin
      n_fail++; $display("FAIL rd_data: got %h expected a5c3c3", {rd_h[18 + RW], rd_h[19 + RW], rd_h[25]});
    end
    n_checks++;
    if ({rdy_h[19 + RW], rdy_h[20 + RW]} !== 2'b01) begin
      n_fail++; $display("FAIL rd_ready: got %b expected 01", {rdy_h[19 + RW], rdy_h[20 + RW]});
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] b2b [0:3];
    logic       ss_t [0:59];
    int         falls [$];
    int         sent, lows;
    bit         hs;
    b2b[0] = 10'h021; b2b[1] = 10'h142; b2b[2] = 10'h284; b2b[3] = 10'h118;
    frames_q.delete();
    sent = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = b2b[0][9:8]; cmd_data = b2b[0][7:0];
    for (int n = 0; n < 60; n++) begin
      ss_t[n] = ss_n;
      hs = cmd_valid && cmd_ready;
      @(negedge clk);
      if (hs) begin
        sent++;
        // Next command goes on the bus during START of the current one; it must wait for IDLE.
        if (sent < 4) begin cmd_op = b2b[sent][9:8]; cmd_data = b2b[sent][7:0]; end
        else cmd_valid = 1'b0;
      end
    end
    n_checks++;
    if (frames_q.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d frames expected 4", frames_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= frames_q.size() || frames_q[i] !== b2b[i]) begin
        n_fail++; $display("FAIL b2b_frame%0d: got %h expected %h", i,
                           (i < frames_q.size()) ? frames_q[i] : 10'h3ff, b2b[i]);
      end
    end
    lows = 0;
    for (int k = 0; k < 60; k++) if (ss_t[k] === 1'b0) lows++;
    for (int k = 1; k < 60; k++) if (ss_t[k - 1] === 1'b1 && ss_t[k] === 1'b0) falls.push_back(k);
    n_checks++;
    if (falls.size() != 4 || lows != 44) begin
      n_fail++; $display("FAIL b2b_frames_low: got %0d frames %0d low cycles expected 4 44", falls.size(), lows);
    end
    // High run between frames: IDLE_GAP cycles of GAP plus the IDLE cycle that accepts the next command.
    for (int i = 0; i + 1 < falls.size(); i++) begin
      n_checks++;
      if (falls[i + 1] - falls[i] - 11 != GAP + 1) begin
        n_fail++; $display("FAIL b2b_gap%0d: got %0d high cycles expected %0d", i,
                           falls[i + 1] - falls[i] - 11, GAP + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int pulses;
    logic [11:0] got;
    send(2'b00, 8'h77, ok);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
    end
    n_checks++;
    if ({ok, busy, ss_n, MOSI} !== 4'b1101) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b expected 1101", {ok, busy, ss_n, MOSI});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {ss_n, MOSI, busy, rsp_valid, rsp_data};
    n_checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00} || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h expected 800", got);
    end
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || ss_n !== 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", pulses);
    end
    frames_q.delete();
    send(2'b01, 8'h33, ok);
    capture(14, 1'b1);
    n_checks++;
    if (!ok || shift_bits() !== 10'b0100110011 || frames_q.size() != 1) begin
      n_fail++; $display("FAIL rst_mid_next_frame: got %b expected 0100110011", shift_bits());
    end
  endtask

  task automatic test_payload_change_nowait();
    bit ok;
    int pulses;
    logic [7:0] pat;
    logic rv_n [0:24];
    logic rdy_n [0:24];
    logic [7:0] rd_n [0:24];
    send(2'b01, 8'h3C, ok);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
      if (k == 3) begin cmd_op = 2'b10; cmd_data = 8'hFF; end
      mosi_h[k] = MOSI;
    end
    n_checks++;
    if (!ok || shift_bits() !== 10'b0100111100) begin
      n_fail++; $display("FAIL latch_bits: got %b expected 0100111100", shift_bits());
    end

    pat = 8'h96;
    @(negedge clk);
    nw_cmd_valid = 1'b1; nw_cmd_op = 2'b11; nw_cmd_data = 8'h00;
    n_checks++;
    if (nw_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL nowait_ready: got %b expected 1", nw_cmd_ready);
    end
    @(posedge clk);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) nw_cmd_valid = 1'b0;
      // MISO is held high outside the reply window so a sample taken one cycle off shows up.
      nw_miso = (k >= 11 && k <= 18) ? pat[7 - (k - 11)] : 1'b1;
      rv_n[k] = nw_rsp_valid; rdy_n[k] = nw_cmd_ready; rd_n[k] = nw_rsp_data;
    end
    nw_miso = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) if (rv_n[k] === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1 || rv_n[19] !== 1'b1) begin
      n_fail++; $display("FAIL nowait_pulse: got %0d pulses expected 1 at cycle 19", pulses);
    end
    n_checks++;
    if (rd_n[19] !== 8'h96) begin
      n_fail++; $display("FAIL nowait_data: got %h expected 96", rd_n[19]);
    end
    n_checks++;
    if ({rdy_n[19], rdy_n[20]} !== 2'b01) begin
      n_fail++; $display("FAIL nowait_ready_back: got %b expected 01", {rdy_n[19], rdy_n[20]});
    end
  endtask

  initial begin
    test_reset();
    test_wr_addr();
    test_wrapper_seq();
    test_rd_data();
    test_back_to_back();
    test_reset_mid_frame();
    test_payload_change_nowait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
